io_uart_tx: RTL and testbench
=============================

# io_uart_tx

Memory-mapped, parametrised UART transmitter for the NextCore IO bus. It sits behind the core's 8-bit IO address / 32-bit data port, next to the GPIO block. It replaces the single-register UART output with:
- a configurable-depth TX FIFO
- a runtime-programmable baud divisor
- a status/control CSR
- a level interrupt

## Interface

Parameters:
- BASE_ADDR, 8'h10: IO byte address of register 0; registers sit at BASE_ADDR+0/+4/+8.
- FIFO_DEPTH, 8: TX FIFO entries; power of two, minimum 2.
- DIV_WIDTH, 16: baud divisor register width.
- DEFAULT_DIV, 16'd434: divisor value loaded at reset.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- io_addr  in  8  IO byte address.
- io_wdata  in  32  write data.
- io_we  in  1  write strobe, one cycle per access.
- io_re  in  1  read strobe, one cycle per access.
- io_rdata  out  32  read data, registered.
- tx  out  1  serial line, idle high.
- irq  out  1  level interrupt.

## Operation

Register map (all other offsets: writes ignored, reads return 0):
- +0 DATA
  - Write pushes io_wdata[7:0] into the FIFO.
  - Read returns 0.
- +4 CSR read:
  - bit0 busy (serializer not IDLE)
  - bit1 full
  - bit2 empty
  - bit3 overflow (sticky)
  - bit4 irq_en
  - bits[15:8] FIFO level
- +4 CSR write:
  - bit4 sets irq_en.
  - Writing 1 to bit3 clears overflow.
- +8 DIV
  - Read/write of the divisor, width DIV_WIDTH; zero-extended on read.
  - A written value of 0 is stored as 1.

FIFO behaviour:
- A push while full (and no pop that cycle) drops the byte and sets overflow.
- Push and pop in the same cycle when full: both occur, level unchanged, no overflow.
- Push and pop in the same cycle when empty is impossible, because a pop requires non-empty at the start of the cycle.

Serializer FSM:
- States: IDLE, START, DATA, PARITY (present only with the macro enabled), STOP.
- IDLE with FIFO non-empty: pop the byte into the shift register, latch DIV into the bit counter reload, go to START.
- Each state holds its bit for exactly DIV clocks.
- DATA sends 8 bits LSB first.
- STOP returns to IDLE. If the FIFO is non-empty at that point, the next frame starts immediately, with no extra idle bit.
- A DIV write mid-frame takes effect at the next frame's START.

irq = irq_en & empty & ~busy.

## Timing

Reset values:
- tx=1, io_rdata=0, irq=0
- DIV=DEFAULT_DIV, FIFO empty, irq_en=0, overflow=0, FSM IDLE

Latencies:
- io_rdata is valid the cycle after io_re and holds until the next io_re.
- Write to DATA at edge N: empty=0 after N. Pop and tx=0 after edge N+1.
- Frame length is 10×DIV clocks, or 11×DIV with parity.
- busy deasserts on the edge that ends STOP.

Reset mid-frame aborts the frame: tx returns high immediately (asynchronously) and FIFO contents are discarded.

CSR reads in the same cycle as a push or pop report the pre-edge state.

## Configuration

Macro IO_UART_TX_PARITY_EN:
- Defined: PARITY state inserted between DATA and STOP, transmitting even parity (XOR of the 8 data bits), DIV clocks long. CSR bit5 reads 1.
- Undefined: no PARITY state, 10-bit frames, CSR bit5 reads 0.

## Test plan

- Reset default: assert rst_n=0 mid-simulation → tx=1, irq=0, DIV reads 434, CSR reads 0x00000004.
- Basic frame: DIV=4, write 0x55 to DATA → tx low 4 cycles starting one cycle after the write edge, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; busy high for 40 cycles.
- Parity (macro on): DIV=4, write 0x07 → parity bit 1, frame 44 cycles. Write 0x55 → parity bit 0.
- FIFO fill and overflow, FIFO_DEPTH=8, DIV=100:
  - Write 10 bytes back-to-back → first popped immediately, 8 held.
  - CSR full=1, level=8, overflow=1.
  - Write CSR 0x08 → overflow clears.
  - All 9 accepted bytes appear on tx in order, with no gap between frames.
- Interrupt: CSR write 0x10, write one byte, DIV=2 → irq=0 during the frame, rises the cycle busy falls; writing CSR 0x00 drops irq.
- Divisor edge cases:
  - Write DIV=0 → reads back 1; 0xA5 sent at 1 clock per bit.
  - Write DIV=8 mid-frame → current frame keeps the old rate; the next frame uses 8.

Source files
------------

// File: rtl/io_uart_tx.sv
// Memory-mapped UART transmitter: TX FIFO, programmable baud divisor, CSR and level irq.
// Define IO_UART_TX_PARITY_EN to add an even-parity bit between the data bits and stop.
module io_uart_tx #(
   parameter logic [7:0]           BASE_ADDR   = 8'h10,
   parameter int                   FIFO_DEPTH  = 8,
   parameter int                   DIV_WIDTH   = 16,
   parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 434
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  io_addr,
   input  logic [31:0] io_wdata,
   input  logic        io_we,
   input  logic        io_re,
   output logic [31:0] io_rdata,
   output logic        tx,
   output logic        irq
);
   // state  | meaning
   // IDLE   | line high, waiting for a FIFO entry
   // START  | start bit (low)
   // DATA   | 8 data bits, LSB first
   // PARITY | even parity bit (parity build only)
   // STOP   | stop bit (high); may chain straight into the next START
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef IO_UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_e;

   localparam int         AW     = $clog2(FIFO_DEPTH);
   localparam int         CW     = AW + 1;
   localparam logic [7:0] A_DATA = BASE_ADDR;
   localparam logic [7:0] A_CSR  = BASE_ADDR + 8'd4;
   localparam logic [7:0] A_DIV  = BASE_ADDR + 8'd8;
`ifdef IO_UART_TX_PARITY_EN
   localparam logic       PAR_EN = 1'b1;
`else
   localparam logic       PAR_EN = 1'b0;
`endif

   state_e                 state_q;
   logic                   tx_q;
   logic [7:0]             sh_q;
   logic [2:0]             idx_q;
   logic [DIV_WIDTH-1:0]   baud_q, rld_q, div_q, wdiv;
   logic                   irq_en_q, ovf_q;
   logic [31:0]            rdata_q, csr;
   logic [7:0]             mem_q [FIFO_DEPTH];
   logic [AW-1:0]          wptr_q, rptr_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   full, empty, busy, tick, pop, push, push_req;
   logic [7:0]             head;
   logic                   unused_wdata;
`ifdef IO_UART_TX_PARITY_EN
   logic                   par_q;
`endif

   assign full     = (cnt_q == CW'(FIFO_DEPTH));
   assign empty    = (cnt_q == '0);
   assign busy     = (state_q != S_IDLE);
   assign tick     = (baud_q == '0);
   assign head     = mem_q[rptr_q];
   assign pop      = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && tick));
   assign push_req = io_we && (io_addr == A_DATA);
   // A full FIFO still accepts a push when the serializer pops on the same edge.
   assign push     = push_req && (!full || pop);
   assign wdiv     = io_wdata[DIV_WIDTH-1:0];
   assign csr      = {16'd0, 8'(cnt_q), 2'd0, PAR_EN, irq_en_q, ovf_q, empty, full, busy};
   assign unused_wdata = ^io_wdata;

   always_comb begin
      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= io_wdata[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q    <= DEFAULT_DIV;
         irq_en_q <= 1'b0;
         ovf_q    <= 1'b0;
         rdata_q  <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop)  rptr_q <= rptr_q + AW'(1);
         if (push_req && full && !pop)
            ovf_q <= 1'b1;
         else if (io_we && (io_addr == A_CSR) && io_wdata[3])
            ovf_q <= 1'b0;
         if (io_we && (io_addr == A_CSR)) irq_en_q <= io_wdata[4];
         if (io_we && (io_addr == A_DIV)) div_q <= (wdiv == '0) ? DIV_WIDTH'(1) : wdiv;
         if (io_re) begin
            case (io_addr)
               A_CSR:   rdata_q <= csr;
               A_DIV:   rdata_q <= 32'(div_q);
               default: rdata_q <= '0;
            endcase
         end
      end
   end

   // baud_q counts down from DIV-1; each bit ends on the edge where it reads zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         tx_q    <= 1'b1;
         sh_q    <= '0;
         idx_q   <= '0;
         baud_q  <= '0;
         rld_q   <= '0;
`ifdef IO_UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else if (pop) begin
         state_q <= S_START;
         tx_q    <= 1'b0;
         sh_q    <= head;
         baud_q  <= div_q - DIV_WIDTH'(1);
         rld_q   <= div_q - DIV_WIDTH'(1);
`ifdef IO_UART_TX_PARITY_EN
         par_q   <= ^head;
`endif
      end else if (busy && !tick) begin
         baud_q <= baud_q - DIV_WIDTH'(1);
      end else begin
         baud_q <= rld_q;
         case (state_q)
            S_START: begin
               state_q <= S_DATA;
               tx_q    <= sh_q[0];
               idx_q   <= '0;
            end
            S_DATA: begin
               if (idx_q == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
                  state_q <= S_PARITY;
                  tx_q    <= par_q;
`else
                  state_q <= S_STOP;
                  tx_q    <= 1'b1;
`endif
               end else begin
                  tx_q  <= sh_q[1];
                  sh_q  <= sh_q >> 1;
                  idx_q <= idx_q + 3'd1;
               end
            end
`ifdef IO_UART_TX_PARITY_EN
            S_PARITY: begin
               state_q <= S_STOP;
               tx_q    <= 1'b1;
            end
`endif
            S_STOP:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign tx       = tx_q;
   assign io_rdata = rdata_q;
   assign irq      = irq_en_q & empty & ~busy;

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx: randomized bytes/divisors against a frame-level model.
// Frame shape follows IO_UART_TX_PARITY_EN when it is defined for the build.
module tb_io_uart_tx;
`ifdef IO_UART_TX_PARITY_EN
   localparam int   NB  = 11;
   localparam logic PAR = 1'b1;
`else
   localparam int   NB  = 10;
   localparam logic PAR = 1'b0;
`endif
   localparam logic [7:0]  A_DATA  = 8'h10;
   localparam logic [7:0]  A_CSR   = 8'h14;
   localparam logic [7:0]  A_DIV   = 8'h18;
   localparam logic [31:0] CSR_PAR = PAR ? 32'h20 : 32'h0;

   logic        clk, rst_n;
   logic [7:0]  io_addr;
   logic [31:0] io_wdata, io_rdata;
   logic        io_we, io_re, tx, irq;
   int          n_checks, n_fail;
   logic        cap_tx[$];
   logic        cap_irq[$];

   io_uart_tx dut (
      .clk(clk), .rst_n(rst_n), .io_addr(io_addr), .io_wdata(io_wdata),
      .io_we(io_we), .io_re(io_re), .io_rdata(io_rdata), .tx(tx), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic io_write(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      io_addr = a; io_wdata = d; io_we = 1'b1;
      @(negedge clk);
      io_we = 1'b0;
   endtask

   task automatic io_read(input logic [7:0] a, output logic [31:0] d);
      @(negedge clk);
      io_addr = a; io_re = 1'b1;
      @(negedge clk);
      io_re = 1'b0;
      d = io_rdata;
   endtask

   task automatic capture(input int n);
      repeat (n) begin
         @(negedge clk);
         cap_tx.push_back(tx);
         cap_irq.push_back(irq);
      end
   endtask

   // Expected line level j clocks after the first START began, frames back to back.
   function automatic logic exp_tx(input int j, input logic [7:0] bq[$], input int dq[$]);
      int t, k;
      t = j;
      for (int f = 0; f < bq.size(); f++) begin
         if (t < NB * dq[f]) begin
            k = t / dq[f];
            if (k == 0) return 1'b0;
            if (k <= 8) return bq[f][k-1];
            if (PAR && k == 9) return ^bq[f];
            return 1'b1;
         end
         t = t - NB * dq[f];
      end
      return 1'b1;
   endfunction

   function automatic int count_tx_errs(input int skip, input logic [7:0] bq[$], input int dq[$],
                                        output int first, output logic fg, output logic fw);
      int   errs;
      logic e;
      errs = 0; first = -1; fg = 1'b0; fw = 1'b0;
      for (int s = skip; s < cap_tx.size(); s++) begin
         e = exp_tx(s - skip, bq, dq);
         if (cap_tx[s] !== e) begin
            if (errs == 0) begin first = s; fg = cap_tx[s]; fw = e; end
            errs++;
         end
      end
      return errs;
   endfunction

   task automatic test_reset();
      logic [31:0] d;
      int          errs;
      io_write(A_DIV, 32'd100);
      io_write(A_DATA, 32'($urandom_range(0, 255)));
      repeat (50) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx_async: tx=%b expected 1", tx); end
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: irq=%b expected 0", irq); end
      @(negedge clk);
      n_checks++;
      if (io_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", io_rdata); end
      rst_n = 1'b1;
      io_read(A_DIV, d);
      n_checks++;
      if (d !== 32'd434) begin n_fail++; $display("FAIL reset_div: got %0d expected 434", d); end
      io_read(A_CSR, d);
      n_checks++;
      if (d !== (32'h4 | CSR_PAR)) begin n_fail++; $display("FAIL reset_csr: got %h expected %h", d, 32'h4 | CSR_PAR); end
      cap_tx.delete(); cap_irq.delete();
      capture(20);
      errs = 0;
      foreach (cap_tx[s]) if (cap_tx[s] !== 1'b1) errs++;
      n_checks++;
      if (errs != 0) begin n_fail++; $display("FAIL reset_fifo_flushed: %0d low samples after reset, expected 0", errs); end
   endtask

   task automatic test_basic_frame();
      logic [7:0]  bq[$];
      int          dq[$];
      int          errs, first, dv;
      logic        fg, fw;
      logic [7:0]  b;
      logic [31:0] d;
      for (int t = 0; t < 4; t++) begin
         b  = (t == 0) ? 8'h55 : 8'($urandom);
         dv = (t == 0) ? 4 : int'($urandom_range(1, 5));
         io_write(A_DIV, 32'(dv));
         io_write(A_DATA, {24'd0, b});
         bq.delete(); dq.delete();
         bq.push_back(b); dq.push_back(dv);
         cap_tx.delete(); cap_irq.delete();
         capture(NB * dv + 2);
         errs = count_tx_errs(0, bq, dq, first, fg, fw);
         n_checks++;
         if (errs != 0) begin
            n_fail++;
            $display("FAIL basic_frame byte=%h div=%0d: %0d bad samples, first at %0d got %b expected %b",
                     b, dv, errs, first, fg, fw);
         end
      end
      io_read(A_CSR, d);
      n_checks++;
      if (d !== (32'h4 | CSR_PAR)) begin n_fail++; $display("FAIL basic_idle_csr: got %h expected %h", d, 32'h4 | CSR_PAR); end
   endtask

`ifdef IO_UART_TX_PARITY_EN
   task automatic test_parity();
      logic [7:0] vals[2];
      logic       want[2];
      vals[0] = 8'h07; want[0] = 1'b1;
      vals[1] = 8'h55; want[1] = 1'b0;
      io_write(A_DIV, 32'd4);
      for (int i = 0; i < 2; i++) begin
         io_write(A_DATA, {24'd0, vals[i]});
         cap_tx.delete(); cap_irq.delete();
         capture(46);
         n_checks++;
         if (cap_tx[37] !== want[i]) begin
            n_fail++; $display("FAIL parity_bit byte=%h: got %b expected %b", vals[i], cap_tx[37], want[i]);
         end
         n_checks++;
         if (cap_tx[35] !== 1'b0 || cap_tx[43] !== 1'b1) begin
            n_fail++; $display("FAIL parity_frame byte=%h: last data=%b stop=%b expected 0/1", vals[i], cap_tx[35], cap_tx[43]);
         end
      end
   endtask
`endif

   task automatic test_fifo_overflow();
      logic [7:0]  b[10];
      logic [7:0]  bq[$];
      int          dq[$];
      logic [31:0] d;
      int          errs, first;
      logic        fg, fw;
      for (int i = 0; i < 10; i++) b[i] = 8'($urandom);
      for (int i = 0; i < 9; i++) begin bq.push_back(b[i]); dq.push_back(100); end
      io_write(A_DIV, 32'd100);
      cap_tx.delete(); cap_irq.delete();
      @(negedge clk);
      io_addr = A_DATA; io_wdata = {24'd0, b[0]}; io_we = 1'b1;
      fork
         capture(9 * NB * 100 + 10);
         begin
            for (int i = 1; i < 10; i++) begin
               @(negedge clk);
               io_wdata = {24'd0, b[i]};
            end
            @(negedge clk);
            io_we = 1'b0;
            io_read(A_CSR, d);
            n_checks++;
            if (d !== (32'h80B | CSR_PAR)) begin n_fail++; $display("FAIL fifo_full_csr: got %h expected %h", d, 32'h80B | CSR_PAR); end
            io_write(A_CSR, 32'h08);
            io_read(A_CSR, d);
            n_checks++;
            if (d !== (32'h803 | CSR_PAR)) begin n_fail++; $display("FAIL fifo_ovf_clear: got %h expected %h", d, 32'h803 | CSR_PAR); end
         end
      join
      errs = count_tx_errs(1, bq, dq, first, fg, fw);
      n_checks++;
      if (errs != 0) begin
         n_fail++;
         $display("FAIL fifo_stream: %0d bad samples, first at %0d got %b expected %b", errs, first, fg, fw);
      end
      io_read(A_CSR, d);
      n_checks++;
      if (d !== (32'h4 | CSR_PAR)) begin n_fail++; $display("FAIL fifo_drained_csr: got %h expected %h", d, 32'h4 | CSR_PAR); end
   endtask

   task automatic test_irq();
      logic [7:0] bq[$];
      int         dq[$];
      int         errs, first;
      logic       fg, fw;
      logic [7:0] b;
      b = 8'($urandom);
      io_write(A_CSR, 32'h10);
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_idle_enabled: irq=%b expected 1", irq); end
      io_write(A_DIV, 32'd2);
      io_write(A_DATA, {24'd0, b});
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_push: irq=%b expected 0", irq); end
      cap_tx.delete(); cap_irq.delete();
      capture(NB * 2 + 3);
      errs = 0; first = -1;
      foreach (cap_irq[j]) begin
         if (cap_irq[j] !== (j >= NB * 2)) begin
            if (errs == 0) first = j;
            errs++;
         end
      end
      n_checks++;
      if (errs != 0) begin
         n_fail++;
         $display("FAIL irq_timing: %0d bad samples, first at %0d got %b expected %b",
                  errs, first, cap_irq[first], first >= NB * 2);
      end
      bq.push_back(b); dq.push_back(2);
      errs = count_tx_errs(0, bq, dq, first, fg, fw);
      n_checks++;
      if (errs != 0) begin n_fail++; $display("FAIL irq_frame: %0d bad samples, first at %0d got %b expected %b", errs, first, fg, fw); end
      io_write(A_CSR, 32'h00);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_disable: irq=%b expected 0", irq); end
   endtask

   task automatic test_div_edge();
      logic [7:0]  bq[$];
      int          dq[$];
      logic [31:0] d;
      int          errs, first;
      logic        fg, fw;
      logic [7:0]  b1, b2;
      io_write(A_DIV, 32'd0);
      io_read(A_DIV, d);
      n_checks++;
      if (d !== 32'd1) begin n_fail++; $display("FAIL div_zero_read: got %0d expected 1", d); end
      io_write(A_DATA, 32'hA5);
      cap_tx.delete(); cap_irq.delete();
      capture(NB + 3);
      bq.push_back(8'hA5); dq.push_back(1);
      errs = count_tx_errs(0, bq, dq, first, fg, fw);
      n_checks++;
      if (errs != 0) begin n_fail++; $display("FAIL div_one_frame: %0d bad samples, first at %0d got %b expected %b", errs, first, fg, fw); end

      b1 = 8'($urandom); b2 = 8'($urandom);
      io_write(A_DIV, 32'd3);
      cap_tx.delete(); cap_irq.delete();
      @(negedge clk);
      io_addr = A_DATA; io_wdata = {24'd0, b1}; io_we = 1'b1;
      fork
         capture(NB * 3 + NB * 8 + 5);
         begin
            @(negedge clk);
            io_wdata = {24'd0, b2};
            @(negedge clk);
            io_we = 1'b0;
            repeat (3) @(negedge clk);
            io_write(A_DIV, 32'd8);
         end
      join
      bq.delete(); dq.delete();
      bq.push_back(b1); dq.push_back(3);
      bq.push_back(b2); dq.push_back(8);
      errs = count_tx_errs(1, bq, dq, first, fg, fw);
      n_checks++;
      if (errs != 0) begin n_fail++; $display("FAIL div_midframe: %0d bad samples, first at %0d got %b expected %b", errs, first, fg, fw); end
      io_read(A_DIV, d);
      n_checks++;
      if (d !== 32'd8) begin n_fail++; $display("FAIL div_readback: got %0d expected 8", d); end
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      rst_n = 1'b0; io_addr = '0; io_wdata = '0; io_we = 1'b0; io_re = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_basic_frame();
`ifdef IO_UART_TX_PARITY_EN
      test_parity();
`endif
      test_fifo_overflow();
      test_irq();
      test_div_edge();
      test_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
